sn74ls606_ctrl: RTL
===================

Name: sn74ls606_ctrl

Overview:
- Controller that shares one sn74ls606 (two octal registers, both loaded on one clk rising edge, ab-selected output) between two independent writers, A and B.
- Keeps shadow copies of both register contents, so one load pulse updates the requested channel(s) and rewrites the other with its old value.
- Generates the '606 load pulse (reg_clk) and the output select (ab), either fixed or as a timed A/B scan for a downstream display or bus.

Parameters:
SETUP_CYC, 1, cycles reg_a/reg_b are held stable before the reg_clk pulse (0 is treated as 1)
DWELL, 4, cycles per ab phase in scan mode (0 is treated as 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
req_a  input  1  writer A request, level
da  input  8  writer A data, sampled only in the IDLE grant cycle
ack_a  output  1  one-cycle pulse: A data stored in the '606
req_b  input  1  writer B request, level
db  input  8  writer B data, sampled only in the IDLE grant cycle
ack_b  output  1  one-cycle pulse: B data stored in the '606
scan_en  input  1  1 = ab alternates automatically, 0 = ab follows sel
sel  input  1  manual select, 1 = A, 0 = B
reg_a  output  8  drives '606 a inputs
reg_b  output  8  drives '606 b inputs
reg_clk  output  1  drives '606 clk
ab  output  1  drives '606 ab (1 = A)
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Reset state (rst high at an edge):
  - state = IDLE; reg_a = reg_b = 8'h00.
  - reg_clk = 0; ack_a = ack_b = 0; busy = 0.
  - ab = 1; dwell counter = 0; grant mask = 00.
- Reset wins over every other event, including mid-transaction: no ack is issued and reg_clk drops on the next cycle.
- Write FSM states: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
  - IDLE: if req_a or req_b is high in cycle T:
    - Grant mask = {req_a, req_b}; both writers are granted together if both request.
    - reg_a <= da if A is granted; reg_b <= db if B is granted. Non-granted registers keep their shadow value.
    - Next state is SETUP with setup counter = SETUP_CYC-1.
  - SETUP: lasts exactly SETUP_CYC cycles with reg_clk = 0, then STROBE.
  - STROBE: exactly 1 cycle, reg_clk = 1. reg_a/reg_b are stable across the reg_clk rising and falling edges.
  - ACK: exactly 1 cycle. reg_clk = 0; ack_a/ack_b = 1 for the granted channels only. Then IDLE.
- Latency for a request sampled in cycle T:
  - reg_x valid at T+1.
  - reg_clk high in cycle T+1+SETUP_CYC.
  - ack in cycle T+2+SETUP_CYC.
  - IDLE again at T+3+SETUP_CYC.
- Requests are not sampled outside IDLE; a request raised while busy waits until the next IDLE. da/db may change freely after the grant cycle.
- A req still high in the first IDLE cycle after ack is a new transaction. Writers drop req on the cycle after their ack.
- The reg_a/reg_b shadows are never modified outside the IDLE grant.
- Scan/select logic runs independently of the write FSM.
  - scan_en = 0: ab <= sel (1-cycle latency); dwell counter held at 0.
  - scan_en = 1, first cycle after a 0->1 transition: ab <= 1 and the counter starts. Each phase lasts exactly DWELL cycles, then ab toggles: A, B, A, ... The counter wraps DWELL-1 -> 0 with a toggle.
  - Deasserting scan_en mid-phase hands ab to sel on the next cycle.
- ab changes never affect reg_clk or the stored values.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs -> reg_a=reg_b=00, reg_clk=0, ab=1, ack_a=ack_b=0, busy=0.
- Single write, SETUP_CYC=1: req_a with da=CC at T -> reg_a=CC at T+1 and reg_b stays 00; reg_clk=1 only in T+2; ack_a=1 only in T+3; ack_b never high; busy low at T+4.
- Simultaneous writes: req_a da=CC and req_b db=AA in the same cycle -> one reg_clk pulse; ack_a and ack_b both high in the same cycle; sel=1 then 0 gives ab=1 then 0, and the '606 model shows y=CC then AA.
- Shadow preservation and queuing: after the previous test, raise req_b db=55 during SETUP of a req_a da=0F write -> first transaction loads reg_a=0F with reg_b=AA; then IDLE grants B with reg_b=55 and reg_a=0F unchanged; two reg_clk pulses total; ack_a precedes ack_b.
- Scan, DWELL=4: scan_en 0->1 -> ab=1 for 4 cycles, 0 for 4, 1 for 4. Drop scan_en with sel=0 while ab=1 -> ab=0 the next cycle.
- Reset mid-operation: assert rst during STROBE -> reg_clk=0 and reg_a=reg_b=00 the next cycle; no ack ever issued for that transaction; the FSM accepts a new request after rst drops.

Source files
------------

// File: rtl/sn74ls606_ctrl_if.sv
// Writer / select / '606 pin bundle for sn74ls606_ctrl.
// master = writers plus the '606 side, slave = controller.
interface sn74ls606_ctrl_if;
  logic       req_a;
  logic [7:0] da;
  logic       ack_a;
  logic       req_b;
  logic [7:0] db;
  logic       ack_b;
  logic       scan_en;
  logic       sel;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic       reg_clk;
  logic       ab;
  logic       busy;

  modport master (
    output req_a, da, req_b, db,
    output scan_en, sel,
    input  ack_a, ack_b,
    input  reg_a, reg_b, reg_clk,
    input  ab, busy
  );

  modport slave (
    input  req_a, da, req_b, db,
    input  scan_en, sel,
    output ack_a, ack_b,
    output reg_a, reg_b, reg_clk,
    output ab, busy
  );
endinterface

// File: rtl/sn74ls606_ctrl.sv
// Shares one sn74ls606 between writers A and B via shadowed
// register contents; also drives the ab select (fixed or scanned).
module sn74ls606_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned DWELL     = 4
) (
  input logic              clk,
  input logic              rst,
  sn74ls606_ctrl_if.slave  bus
);

  localparam int unsigned SC =
    (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned DW =
    (DWELL == 0) ? 1 : DWELL;
  localparam int SCW = (SC > 1) ? $clog2(SC) : 1;
  localparam int DWW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(SC - 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [7:0]     reg_a_q, reg_a_d;
  logic [7:0]     reg_b_q, reg_b_d;
  logic           reg_clk_q, reg_clk_d;
  logic           ack_a_q, ack_a_d;
  logic           ack_b_q, ack_b_d;
  logic           ab_q, ab_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic           scan_q, scan_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    reg_clk_d = 1'b0;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          gnt_d   = {bus.req_a, bus.req_b};
          state_d = SETUP;
          cnt_d   = SC_LAST;
          if (bus.req_a) reg_a_d = bus.da;
          if (bus.req_b) reg_b_d = bus.db;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d   = STROBE;
          reg_clk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      STROBE: begin
        state_d = ACK;
        ack_a_d = gnt_q[1];
        ack_b_d = gnt_q[0];
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan runs beside the write FSM; a fresh scan_en edge restarts on A.
  always_comb begin
    scan_d  = bus.scan_en;
    ab_d    = ab_q;
    dwell_d = dwell_q;
    if (!bus.scan_en) begin
      ab_d    = bus.sel;
      dwell_d = '0;
    end else if (!scan_q) begin
      ab_d    = 1'b1;
      dwell_d = '0;
    end else if (dwell_q == DW_LAST) begin
      ab_d    = ~ab_q;
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + DWW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= 2'b00;
      reg_a_q   <= 8'h00;
      reg_b_q   <= 8'h00;
      reg_clk_q <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      ab_q      <= 1'b1;
      dwell_q   <= '0;
      scan_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      reg_clk_q <= reg_clk_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      ab_q      <= ab_d;
      dwell_q   <= dwell_d;
      scan_q    <= scan_d;
    end
  end

  assign bus.reg_a   = reg_a_q;
  assign bus.reg_b   = reg_b_q;
  assign bus.reg_clk = reg_clk_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.ab      = ab_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
